// File: rtl/ram_frame_sched.sv
// ram_frame_sched: stereo row-buffer frame sequencer issuing write/read addresses and the bank-rotation fsync
module ram_frame_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_l_valid,
  output logic                  in_l_ready,
  input  logic                  in_r_valid,
  output logic                  in_r_ready,
  output logic                  WLE,
  output logic                  WRE,
  output logic [ADDR_WIDTH-1:0] W_L_addr,
  output logic [ADDR_WIDTH-1:0] W_R_addr,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] R_addr,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  p_valid,
  output logic                  fsync,
  output logic [15:0]           frame_cnt
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] D = CW'(DEPTH);
  localparam logic [CW-1:0] DL = CW'(DEPTH - 1);
  typedef enum logic [1:0] {RUN, DRAIN, SYNC} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] l_cnt_q, l_cnt_d, r_cnt_q, r_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0] sync_seen_q, sync_seen_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic run, sync, rd_issue, rd_done;
  always_comb begin
    run = state_q == RUN;
    sync = state_q == SYNC;
    in_l_ready = run && l_cnt_q < D;
    in_r_ready = run && r_cnt_q < D;
    WLE = in_l_valid && in_l_ready;
    WRE = in_r_valid && in_r_ready;
    rd_issue = run && sync_seen_q != 2'd0 && rd_ready && rd_cnt_q < D;
    l_cnt_d = sync ? '0 : l_cnt_q + CW'(WLE);
    r_cnt_d = sync ? '0 : r_cnt_q + CW'(WRE);
    rd_cnt_d = sync ? '0 : rd_cnt_q + CW'(rd_issue);
    rd_done = sync_seen_q == 2'd0 || rd_cnt_d == D;
    state_d = run ? ((l_cnt_d == D && r_cnt_d == D && rd_done) ? DRAIN : RUN) : (state_q == DRAIN ? SYNC : RUN);
    rd_valid_d = rd_issue;
    rd_last_d = rd_issue && rd_cnt_q == DL;
    frame_cnt_d = frame_cnt_q + 16'(sync);
    sync_seen_d = sync_seen_q + 2'(sync && sync_seen_q != 2'd3);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      l_cnt_q <= '0;
      r_cnt_q <= '0;
      rd_cnt_q <= '0;
      sync_seen_q <= '0;
      frame_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      l_cnt_q <= l_cnt_d;
      r_cnt_q <= r_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      sync_seen_q <= sync_seen_d;
      frame_cnt_q <= frame_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
    end
  end
  assign W_L_addr = l_cnt_q[ADDR_WIDTH-1:0];
  assign W_R_addr = r_cnt_q[ADDR_WIDTH-1:0];
  assign R_addr = rd_cnt_q[ADDR_WIDTH-1:0];
  assign rd_valid = rd_valid_q;
  assign rd_last = rd_last_q;
  assign p_valid = sync_seen_q[1];
  assign fsync = state_q == SYNC;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_ram_frame_sched.sv
// tb_ram_frame_sched: randomized check of ram_frame_sched against a frame-level reference model
module tb_ram_frame_sched;
  localparam int AW = 4;
  localparam int DP = 8;
  logic clk = 1'b0;
  logic rst, lv, rv, rdy;
  logic lr, rr, wle, wre, rdv, rdl, pv, fs;
  logic [AW-1:0] wla, wra, ra;
  logic [15:0] fc;
  logic lr2, rr2, wle2, wre2, rdv2, rdl2, pv2, fs2;
  logic wla2, wra2, ra2;
  logic [15:0] fc2;
  int checks = 0;
  int errors = 0;
  int ml, mr, mrd, frames, gap, cyc;
  logic prev_iss, prev_last;
  always #5 clk = ~clk;
  ram_frame_sched #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .in_l_valid(lv), .in_l_ready(lr), .in_r_valid(rv), .in_r_ready(rr),
    .WLE(wle), .WRE(wre), .W_L_addr(wla), .W_R_addr(wra), .rd_ready(rdy), .R_addr(ra),
    .rd_valid(rdv), .rd_last(rdl), .p_valid(pv), .fsync(fs), .frame_cnt(fc)
  );
  ram_frame_sched #(.ADDR_WIDTH(1), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_l_valid(1'b1), .in_l_ready(lr2), .in_r_valid(1'b1), .in_r_ready(rr2),
    .WLE(wle2), .WRE(wre2), .W_L_addr(wla2), .W_R_addr(wra2), .rd_ready(1'b1), .R_addr(ra2),
    .rd_valid(rdv2), .rd_last(rdl2), .p_valid(pv2), .fsync(fs2), .frame_cnt(fc2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    ml = 0; mr = 0; mrd = 0; frames = 0; gap = 0; prev_iss = 1'b0; prev_last = 1'b0;
  endtask
  task automatic step(input int pl, input int pr, input int prd, input logic r);
    logic running, er, el, iss;
    @(negedge clk);
    cyc++;
    rst = r;
    lv = $urandom_range(99) < pl;
    rv = $urandom_range(99) < pr;
    rdy = prd < 0 ? cyc[0] : ($urandom_range(99) < prd);
    #1;
    running = gap == 0;
    el = running && ml < DP;
    er = running && mr < DP;
    iss = running && frames >= 1 && rdy && mrd < DP;
    check("in_l_ready", lr, el);
    check("in_r_ready", rr, er);
    check("WLE", wle, lv && el);
    check("WRE", wre, rv && er);
    check("W_L_addr", wla, ml % (1 << AW));
    check("W_R_addr", wra, mr % (1 << AW));
    check("R_addr", ra, mrd % (1 << AW));
    check("rd_valid", rdv, prev_iss);
    check("rd_last", rdl, prev_last);
    check("fsync", fs, gap == 1);
    check("frame_cnt", fc, frames % 65536);
    check("p_valid", pv, frames >= 2);
    if (r) begin
      model_reset();
    end else begin
      prev_iss = iss;
      prev_last = iss && mrd == DP - 1;
      if (running) begin
        ml += int'(lv && el);
        mr += int'(rv && er);
        mrd += int'(iss);
        if (ml == DP && mr == DP && (frames == 0 || mrd == DP)) gap = 2;
      end else if (gap == 2) begin
        gap = 1;
      end else begin
        gap = 0; ml = 0; mr = 0; mrd = 0; frames++;
      end
    end
  endtask
  task automatic run_frames(input int n, input int pl, input int pr, input int prd);
    int target;
    target = frames + n;
    for (int i = 0; i < 3000 && frames < target; i++) step(pl, pr, prd, 1'b0);
    check("frame_timeout", frames >= target, 1);
  endtask
  initial begin
    int exp2, prev2;
    logic wrapped;
    cyc = 0;
    rst = 1'b1; lv = 1'b0; rv = 1'b0; rdy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    run_frames(1, 100, 100, 50);
    for (int i = 0; i < 25; i++) step(100, i >= 6 ? 100 : 0, 0, 1'b0);
    run_frames(1, 100, 35, 100);
    run_frames(1, 100, 100, -1);
    run_frames(4, 60, 70, 40);
    run_frames(2, 100, 100, 100);
    for (int i = 0; i < 200 && ml != 5; i++) step(50, 50, 50, 1'b0);
    check("mid_frame_l_cnt", ml, 5);
    step(100, 100, 100, 1'b1);
    run_frames(3, 80, 80, 80);
    for (int i = 0; i < 20 && fs2; i++) @(negedge clk);
    force dut2.frame_cnt_q = 16'd65533;
    #1;
    release dut2.frame_cnt_q;
    exp2 = 65533;
    prev2 = 65533;
    wrapped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("wrap_frame_cnt", fc2, exp2);
      check("wrap_p_valid", pv2, 1);
      if (prev2 == 65535 && fc2 == 16'd0) wrapped = 1'b1;
      prev2 = fc2;
      if (fs2) exp2 = (exp2 + 1) % 65536;
    end
    check("wrap_seen", wrapped, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
